// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial adder/subtractor. A single full-add/full-subtract
//               cell is time-shared over WIDTH clock cycles, LSB first.
//               A start/done handshake captures the operands and reports the
//               result. The result, cout and optional ovf outputs change only
//               when a new result is published.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   : operand/result width in bits (legal range 2..64)
// Ports
//   clk     : in  1      rising-edge clock
//   rst_n   : in  1      asynchronous active-low reset
//   start   : in  1      request; sampled only in IDLE or DONE
//   mode    : in  1      0 = add (a+b), 1 = subtract (a-b); captured with start
//   a       : in  WIDTH  operand A; captured with start
//   b       : in  WIDTH  operand B; captured with start
//   busy    : out 1      high while the serial operation is running
//   done    : out 1      one-cycle pulse; result/cout valid
//   result  : out WIDTH  sum or difference; held until the next done
//   cout    : out 1      add: carry out; sub: borrow out (1 when a<b unsigned)
//   ovf     : out 1      two's-complement overflow (SERIAL_ADDSUB_OVF_EN only)
// Build option
//   SERIAL_ADDSUB_OVF_EN : when defined, adds the ovf output and its logic.
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bit counter is just wide enough to index WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operand shift registers: bit 0 always presents the bit being processed.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_carry;      // carry (add) or borrow (sub) into current bit
  logic [CNT_W-1:0] r_cnt;
  // Holds the WIDTH-1 result bits already produced; the final bit is merged in
  // combinationally on the last RUN edge so the full word loads in one step.
  logic [WIDTH-2:0] r_acc;

  logic             w_ai;
  logic             w_bi;
  logic             w_bit;
  logic             w_carry_next;
  logic             w_last;
  logic             w_capture;
  logic [WIDTH-1:0] w_word;

  // --------------------------------------------------------------------------
  // Arithmetic cell
  // --------------------------------------------------------------------------
  assign w_ai  = r_a[0];
  assign w_bi  = r_b[0];
  // Sum and difference bits share the same XOR form.
  assign w_bit = w_ai ^ w_bi ^ r_carry;

  always_comb begin
    w_carry_next = 1'b0;
    if (r_mode) begin
      w_carry_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_carry);
    end else begin
      w_carry_next = (w_ai & w_bi) | ((w_ai ^ w_bi) & r_carry);
    end
  end

  // New bit enters at the MSB end; after WIDTH shifts bit 0 is the LSB result.
  assign w_word    = {w_bit, r_acc};
  assign w_last    = (r_cnt == C_LAST_BIT);
  assign w_capture = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // start is deliberately ignored here: operands are already committed.
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // Back-to-back requests skip IDLE entirely.
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= b;
      r_mode  <= mode;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_next;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_acc   <= w_word[WIDTH-1:1];
    end
  end

  // Published outputs only move on the final RUN edge (entry to DONE), so no
  // partially computed value is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      result <= w_word;
      cout   <= w_carry_next;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // On the last bit r_carry is the carry/borrow into the MSB and w_carry_next
  // the carry/borrow out of it; their XOR is the signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      ovf <= r_carry ^ w_carry_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH=8). Directed
//               vector table, hand-written multi-cycle sequences and random
//               operations checked against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Last published values the outputs must hold outside the DONE entry.
  logic [W-1:0] prev_r = '0;
  logic         prev_c = 1'b0;
  logic         prev_o = 1'b0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic         m;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-word unsigned arithmetic, signed overflow from signs.
  function automatic void model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] full;
    if (!m) begin
      full = {1'b0, x} + {1'b0, y};
      c    = full[W];
    end else begin
      full = {1'b0, x} - {1'b0, y};
      c    = (x < y);
    end
    r = full[W-1:0];
    if (!m) o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    else    o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Called at a negedge. Launches one operation, checks the RUN window (busy,
  // no done, outputs held) and then the done cycle. Returns at the done negedge.
  task automatic do_op(input string name, input logic m, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er, input logic ec,
                       input logic eo, input bit inject);
    logic run_ok;
    run_ok = 1'b1;
    start = 1'b1; mode = m; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || result !== prev_r || cout !== prev_c) run_ok = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      if (ovf !== prev_o) run_ok = 1'b0;
`endif
      if (inject && k == 3) begin
        start = 1'b1; mode = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, " run_window"}, 64'(run_ok), 64'd1);
    check({name, " busy/done"}, 64'({busy, done}), 64'(2'b01));
    check({name, " result"}, 64'(result), 64'(er));
    check({name, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({name, " ovf"}, 64'(ovf), 64'(eo));
`endif
    prev_r = er; prev_c = ec; prev_o = eo;
  endtask

  // One idle cycle after a done: done must have been a single-cycle pulse.
  task automatic gap(input string name);
    @(negedge clk);
    check({name, " done_width"}, 64'({busy, done}), 64'(2'b00));
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] rr;
    logic         rc;
    logic         ro;
    logic         ok;

    vecs[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h09, 8'h03, 8'h06, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy/done", 64'({busy, done}), 64'(2'b00));
    check("reset result", 64'(result), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("reset ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy/done", 64'({busy, done}), 64'(2'b00));

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].x, vecs[i].y,
            vecs[i].r, vecs[i].c, vecs[i].o, 1'b0);
      gap($sformatf("vec%0d", i));
    end

    // start pulsed with new operands mid-RUN must be ignored
    do_op("ignore_start", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1);
    gap("ignore_start");

    // Back-to-back: start held in the DONE cycle, no IDLE cycle in between
    do_op("b2b_first", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);
    do_op("b2b_second", 1'b1, 8'h09, 8'h03, 8'h06, 1'b0, 1'b0, 1'b0);
    gap("b2b_second");

    // Reset in the middle of RUN
    start = 1'b1; mode = 1'b0; a = 8'h12; b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy before reset", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset busy/done", 64'({busy, done}), 64'(2'b00));
    check("midrun reset result", 64'(result), 64'd0);
    check("midrun reset cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("midrun reset ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || result !== '0) ok = 1'b0;
    end
    check("midrun no done after abort", 64'(ok), 64'd1);
    prev_r = '0; prev_c = 1'b0; prev_o = 1'b0;
    do_op("after_reset", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);
    gap("after_reset");

    // Random operations against the reference model, with random back-to-back
    for (int i = 0; i < 40; i++) begin
      logic         m;
      logic [W-1:0] x;
      logic [W-1:0] y;
      m = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      model(m, x, y, rr, rc, ro);
      do_op($sformatf("rand%0d", i), m, x, y, rr, rc, ro, 1'b0);
      if ($urandom_range(0, 1) == 1) gap($sformatf("rand%0d", i));
    end
    gap("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; one full-add or full-subtract cell time-shared over WIDTH cycles, LSB first.
- Generalises the half-cell add/subtract primitives to N-bit operands, with a runtime mode select and a start/done handshake.
- Sits beside datapath blocks where area matters more than latency: a small counter-driven arithmetic unit.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/cout valid
result  output  WIDTH  sum or difference; held until next DONE
cout  output  1  add: carry out; sub: borrow out (1 when a<b unsigned)

Behaviour:
- Reset: async on rst_n low; state=IDLE. busy, done, result, cout and all internal registers clear to 0. Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 -> RUN. Capture a, b and mode; carry/borrow FF=0; bit counter=0.
  - RUN: each edge processes bit cnt, shifting the result bit into an internal shift register and updating the carry/borrow FF.
    - cnt==WIDTH-1 -> DONE.
    - start is ignored in RUN; operands and mode are not re-sampled.
  - DONE: done=1 for exactly one cycle. result and cout are loaded from internal registers on entry. Next edge: start=1 -> RUN with new capture (back-to-back), else IDLE.
- Cell equations, with c = carry/borrow FF:
  - Add: s=ai^bi^c; c'=(ai&bi)|((ai^bi)&c).
  - Sub: d=ai^bi^c; c'=(~ai&bi)|(~(ai^bi)&c).
- Timing: start sampled at edge T0 -> busy=1 from T0 through T0+WIDTH-1. done=1 in the cycle after edge T0+WIDTH. Latency is WIDTH cycles from start to done.
- busy=0 in IDLE and DONE; busy and done are never high together.
- result/cout change only on entry to DONE and hold their last values otherwise; outputs are not partially updated during RUN.
- Arithmetic is modulo 2^WIDTH and unsigned for cout. Wrap-around, e.g. all-ones+1, gives result 0 with cout=1.
- a, b and mode may change freely after the capture edge without effect.

Optional Feature:
SERIAL_ADDSUB_OVF_EN
- Defined: adds output port ovf (1 bit).
  - Two's-complement overflow = carry/borrow into MSB XOR carry/borrow out of MSB.
  - Updated with result on entry to DONE; held otherwise; reset 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, start with mode=0, a=8'h3C, b=8'h05 -> busy for 8 cycles, then done pulse, result=8'h41, cout=0.
- mode=0, a=8'hFF, b=8'h01 -> result=8'h00, cout=1; then mode=1, a=8'h05, b=8'h07 -> result=8'hFE, cout=1 (borrow).
- During RUN of 8'h10+8'h20, pulse start with a=8'hAA and change a/b -> ignored; result=8'h30 after 8 cycles. Previous result is held on the outputs throughout RUN.
- Hold start=1 in the DONE cycle with mode=1, a=8'h09, b=8'h03 -> no IDLE cycle; busy again next cycle; second done 8 cycles later with result=8'h06, cout=0.
- Drop rst_n at cycle 4 of a RUN -> busy/done/result/cout go to 0 immediately; no done pulse; the next start works normally.
- With SERIAL_ADDSUB_OVF_EN: 8'h7F+8'h01 -> result=8'h80, ovf=1, cout=0. mode=1, 8'h80-8'h01 -> result=8'h7F, ovf=1. 8'h05+8'h03 -> ovf=0.
